// File: rtl/pc_pkg.sv
// Shared constants and operation encoding for the program counter and its return stack.
package pc_pkg;

    localparam int unsigned PC_WIDTH       = 16;
    localparam int unsigned PC_STACK_DEPTH = 8;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD,
        PC_CALL,
        PC_RET,
        PC_RESET
    } pc_op_t;

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO; the pointer carries one extra bit so full and empty are distinct.
module pc_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH,
    parameter int unsigned DEPTH = PC_STACK_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    ptr;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty   = (ptr == PW'(0));
    assign full    = (ptr == PW'(DEPTH));
    assign top_idx = AW'(ptr - PW'(1));
    assign dout    = mem[top_idx];

    // Pointer and sticky error; push wins if both are requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            err <= 1'b0;
        end else if (push) begin
            if (full) err <= 1'b1;
            else      ptr <= ptr + PW'(1);
        end else if (pop) begin
            if (empty) err <= 1'b1;
            else       ptr <= ptr - PW'(1);
        end
    end

    // Storage is intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem[ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/program_counter.sv
// Program counter with priority-encoded hold/inc/load/call/ret/reset.
// Return stack built only when PROGRAM_COUNTER_STACK_EN is defined.
module program_counter
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH,
    parameter int unsigned DEPTH = PC_STACK_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] out,
    output logic             stk_empty,
    output logic             stk_full,
    output logic             stk_err
);

    pc_op_t           op;
    logic [WIDTH-1:0] next_seq;
    logic [WIDTH-1:0] stk_top;

    assign next_seq = out + WIDTH'(1);

    // Fixed-priority request encoder.
    always_comb begin
        op = PC_HOLD;
        if (reset)     op = PC_RESET;
`ifdef PROGRAM_COUNTER_STACK_EN
        else if (call) op = PC_CALL;
        else if (ret)  op = PC_RET;
`else
        else if (call) op = PC_LOAD;
`endif
        else if (load) op = PC_LOAD;
        else if (inc)  op = PC_INC;
    end

`ifdef PROGRAM_COUNTER_STACK_EN
    pc_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (op == PC_CALL),
        .pop   (op == PC_RET),
        .din   (next_seq),
        .dout  (stk_top),
        .empty (stk_empty),
        .full  (stk_full),
        .err   (stk_err)
    );
`else
    localparam int unsigned unused_depth = DEPTH;
    logic unused_ret;

    assign unused_ret = ret;
    assign stk_top    = '0;
    assign stk_empty  = 1'b1;
    assign stk_full   = 1'b0;
    assign stk_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        case (op)
            PC_RESET: out <= '0;
            PC_CALL,
            PC_LOAD:  out <= in;
            PC_RET:   if (!stk_empty) out <= stk_top;
            PC_INC:   out <= next_seq;
            default:  out <= out;
        endcase
    end

endmodule
